idli_ex_fetch_m: RTL and testbench

IDLI_EX_FETCH_M -- requirements
Module: idli_ex_fetch_m

---
 rtl/idli_ex_fetch_m.sv | 182 ++++++++++++++++++
 tb/tb_idli_ex_fetch_m.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_ex_fetch_m.sv
// -----------------------------------------------------------------------------
// idli_ex_fetch_m
//
// Instruction fetch unit. Requests one 16-bit word at a time from memory,
// assembles the word from four returned nibbles (least-significant first),
// and buffers up to two {encoding, pc} pairs for the execute stage. The head
// entry is consumed on the last slice of a word (i_ex_ctr == 3) unless the
// consumer stalls. A redirect flushes the buffer, reloads the fetch PC and,
// if a word is still in flight, drains and discards its remaining nibbles.
//
// Ports
//   i_ex_gck        clock, all state updates on its rising edge
//   i_ex_rst_n      asynchronous active-low reset
//   i_ex_ctr        slice counter, 3 marks the last slice of a word
//   o_mem_req       read request for the word at o_mem_addr
//   o_mem_addr      word address of the request (the fetch PC)
//   i_mem_ack       memory accepts the request this cycle
//   i_mem_data      returned nibble, least-significant nibble first
//   i_mem_data_vld  i_mem_data valid this cycle, gaps allowed
//   i_stall         consumer cannot accept an encoding this word boundary
//   i_redir         redirect fetch and flush buffered encodings
//   i_redir_pc      redirect target word address
//   o_enc           head encoding
//   o_enc_vld       head encoding valid
//   o_pc            word address of o_enc
// -----------------------------------------------------------------------------
module idli_ex_fetch_m (
    input  logic        i_ex_gck,
    input  logic        i_ex_rst_n,
    input  logic [1:0]  i_ex_ctr,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [3:0]  i_mem_data,
    input  logic        i_mem_data_vld,
    input  logic        i_stall,
    input  logic        i_redir,
    input  logic [15:0] i_redir_pc,
    output logic [15:0] o_enc,
    output logic        o_enc_vld,
    output logic [15:0] o_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] pc;          // fetch PC
    logic [15:0] req_pc;      // PC of the word currently being received
    logic [1:0]  nib_cnt;     // nibbles received for the in-flight word
    logic [11:0] word_lo;     // first three nibbles of the in-flight word

    // Two-entry FIFO of {encoding, pc}
    logic [15:0] enc_mem [2];
    logic [15:0] pc_mem  [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_cnt;

    logic        accept;        // request accepted this cycle
    logic        last_nib;      // fourth nibble of the in-flight word arrives
    logic        push;
    logic        pop;
    logic [1:0]  occ_after_pop;

    assign accept   = (state == REQ) && i_mem_ack;
    assign last_nib = i_mem_data_vld && (nib_cnt == 2'd3);

    // A redirect flushes the FIFO, so neither push nor pop applies that cycle.
    assign push = (state == RECV) && last_nib && !i_redir;
    assign pop  = (i_ex_ctr == 2'd3) && (fifo_cnt != 2'd0) && !i_stall && !i_redir;

    assign occ_after_pop = fifo_cnt - {1'b0, pop};

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic. Redirect priority falls out of the structure:
    // it only ever blocks IDLE->REQ or turns a receive into a drain.
    // ---------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this process free of
    // inferred latches on paths where no branch assigns state_nxt.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!i_redir && (occ_after_pop < 2'd2)) state_nxt = REQ;
            REQ:   if (i_mem_ack) state_nxt = i_redir ? DRAIN : RECV;
            // A word completing together with a redirect is simply not pushed.
            RECV:  if (last_nib)     state_nxt = IDLE;
                   else if (i_redir) state_nxt = DRAIN;
            DRAIN: if (last_nib)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        o_mem_req  = (state == REQ);
        o_mem_addr = pc;
        o_enc_vld  = (fifo_cnt != 2'd0);
        o_enc      = enc_mem[rd_ptr];
        o_pc       = pc_mem[rd_ptr];
    end

    // ---------------------------------------------------------------------
    // Fetch PC, request PC, nibble assembly
    // ---------------------------------------------------------------------
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            pc      <= 16'h0000;
            req_pc  <= 16'h0000;
            nib_cnt <= 2'd0;
            word_lo <= 12'h000;
        end else begin
            if (i_redir)     pc <= i_redir_pc;
            else if (accept) pc <= pc + 16'd1;

            if (accept) req_pc <= pc;

            // Counting continues in DRAIN so the discarded word is tracked
            // to its end; the 2-bit counter wraps to 0 on the fourth nibble.
            if (accept)
                nib_cnt <= 2'd0;
            else if (((state == RECV) || (state == DRAIN)) && i_mem_data_vld)
                nib_cnt <= nib_cnt + 2'd1;

            if ((state == RECV) && i_mem_data_vld) begin
                case (nib_cnt)
                    2'd0:    word_lo[3:0]  <= i_mem_data;
                    2'd1:    word_lo[7:4]  <= i_mem_data;
                    2'd2:    word_lo[11:8] <= i_mem_data;
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------------
    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            fifo_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (i_redir) begin
            fifo_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // NOTE: the FIFO storage has no reset; fifo_cnt alone qualifies it, so
    // resetting the data would only add reset fan-out.
    always_ff @(posedge i_ex_gck) begin
        if (push) begin
            enc_mem[wr_ptr] <= {i_mem_data, word_lo};
            pc_mem[wr_ptr]  <= req_pc;
        end
    end

endmodule

// File: tb/tb_idli_ex_fetch_m.sv
// -----------------------------------------------------------------------------
// tb_idli_ex_fetch_m
//
// Self-checking bench for idli_ex_fetch_m. A table of per-cycle vectors covers
// the basic fetch, hand-written sequences cover back-pressure, redirects, PC
// wrap and asynchronous reset, and a randomized phase compares every cycle
// against a transaction-level reference model (queue-based buffer, expected
// words derived from the memory contents).
// -----------------------------------------------------------------------------
module tb_idli_ex_fetch_m;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ctr = 2'd0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [3:0]  mem_data = 4'h0;
    logic        mem_data_vld = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] redir_pc = 16'h0000;
    logic [15:0] enc;
    logic        enc_vld;
    logic [15:0] pc;

    idli_ex_fetch_m dut (
        .i_ex_gck       (clk),
        .i_ex_rst_n     (rst_n),
        .i_ex_ctr       (ctr),
        .o_mem_req      (mem_req),
        .o_mem_addr     (mem_addr),
        .i_mem_ack      (mem_ack),
        .i_mem_data     (mem_data),
        .i_mem_data_vld (mem_data_vld),
        .i_stall        (stall),
        .i_redir        (redir),
        .i_redir_pc     (redir_pc),
        .o_enc          (enc),
        .o_enc_vld      (enc_vld),
        .o_pc           (pc)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: any fixed function of the address; word 0 is 0x1234.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] prod;
        prod = a * 16'h9E37;
        return 16'h1234 ^ prod;
    endfunction

    // ---------------------------------------------------------------------
    // Per-cycle stimulus and memory responder
    // ---------------------------------------------------------------------
    typedef struct {
        logic        ack;
        logic        dv;
        logic [1:0]  ctr;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
    } stim_t;

    function automatic stim_t mk(input logic a, input logic d, input logic [1:0] c,
                                 input logic st, input logic r, input logic [15:0] p);
        stim_t s;
        s.ack = a; s.dv = d; s.ctr = c; s.stall = st; s.redir = r; s.rpc = p;
        return s;
    endfunction

    logic [3:0] pend[$];   // nibbles the memory still owes

    task automatic drive(input stim_t s);
        logic [15:0] w;
        mem_ack      = s.ack;
        mem_data_vld = s.dv;
        if (s.dv && pend.size() > 0) mem_data = pend.pop_front();
        else                         mem_data = 4'($urandom);
        ctr      = s.ctr;
        stall    = s.stall;
        redir    = s.redir;
        redir_pc = s.rpc;
        if (s.ack && mem_req) begin
            w = mem_word(mem_addr);
            for (int k = 0; k < 4; k++) pend.push_back(w[4*k +: 4]);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef enum {M_IDLE, M_REQ, M_RECV, M_DRAIN} mphase_t;
    typedef struct {
        logic [15:0] enc;
        logic [15:0] pc;
    } entry_t;

    entry_t      mq[$];
    mphase_t     m_ph  = M_IDLE;
    logic [15:0] m_pc  = 16'h0000;
    logic [15:0] m_lat = 16'h0000;
    int          m_n   = 0;

    task automatic model_reset();
        mq.delete();
        m_ph = M_IDLE;
        m_pc = 16'h0000;
        m_n  = 0;
    endtask

    task automatic model_step(input stim_t s);
        bit pop;
        pop = (s.ctr == 2'd3) && (mq.size() > 0) && !s.stall;
        if (s.redir) begin
            mq.delete();
            m_pc = s.rpc;
            case (m_ph)
                M_REQ: if (s.ack) begin m_ph = M_DRAIN; m_n = 0; end
                M_RECV, M_DRAIN: begin
                    if (s.dv) m_n++;
                    m_ph = (m_n == 4) ? M_IDLE : M_DRAIN;
                end
                default: ;
            endcase
        end else begin
            if (pop) void'(mq.pop_front());
            case (m_ph)
                M_IDLE: if (mq.size() < 2) m_ph = M_REQ;
                M_REQ: if (s.ack) begin
                    m_lat = m_pc;
                    m_pc  = m_pc + 16'd1;
                    m_n   = 0;
                    m_ph  = M_RECV;
                end
                M_RECV: if (s.dv) begin
                    m_n++;
                    if (m_n == 4) begin
                        mq.push_back('{enc: mem_word(m_lat), pc: m_lat});
                        m_ph = M_IDLE;
                    end
                end
                M_DRAIN: if (s.dv) begin
                    m_n++;
                    if (m_n == 4) m_ph = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic compare_model();
        check("model_req",  32'(mem_req),  32'(m_ph == M_REQ));
        check("model_addr", 32'(mem_addr), 32'(m_pc));
        check("model_vld",  32'(enc_vld),  32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("model_enc", 32'(enc), 32'(mq[0].enc));
            check("model_pc",  32'(pc),  32'(mq[0].pc));
        end
    endtask

    // One clock: drive at the falling edge, advance, compare at the next one.
    task automatic step(input stim_t s);
        drive(s);
        compared++;
        a_no_push_full: assert (!(dut.push && dut.fifo_cnt == 2'd2)) else begin
            mismatched++;
            $display("FAIL push_full: push while occupancy 2 at %0t", $time);
        end
        model_step(s);
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 16'h0));
        pend.delete();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req",  32'(mem_req),  32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_vld",  32'(enc_vld),  32'h0);
        rst_n = 1'b1;
    endtask

    // Apply this cycle's stimulus, then assert reset before the rising edge.
    task automatic reset_mid_cycle(input stim_t s);
        drive(s);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_vld",  32'(enc_vld),  32'h0);
        check("arst_req",  32'(mem_req),  32'h0);
        check("arst_addr", 32'(mem_addr), 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 16'h0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Basic fetch vector table
    // ---------------------------------------------------------------------
    typedef struct {
        stim_t       s;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_vld;
        logic [15:0] exp_enc;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        stim_t s;
        int    bctr;

        // inputs for the cycle -> outputs after the following rising edge
        tbl[0] = '{s: mk(0, 0, 0, 0, 0, 16'h0), exp_req: 1, exp_addr: 16'h0000, exp_vld: 0, exp_enc: 16'h0,    exp_pc: 16'h0};
        tbl[1] = '{s: mk(1, 0, 0, 0, 0, 16'h0), exp_req: 0, exp_addr: 16'h0001, exp_vld: 0, exp_enc: 16'h0,    exp_pc: 16'h0};
        tbl[2] = '{s: mk(0, 1, 0, 0, 0, 16'h0), exp_req: 0, exp_addr: 16'h0001, exp_vld: 0, exp_enc: 16'h0,    exp_pc: 16'h0};
        tbl[3] = '{s: mk(0, 1, 0, 0, 0, 16'h0), exp_req: 0, exp_addr: 16'h0001, exp_vld: 0, exp_enc: 16'h0,    exp_pc: 16'h0};
        tbl[4] = '{s: mk(0, 1, 0, 0, 0, 16'h0), exp_req: 0, exp_addr: 16'h0001, exp_vld: 0, exp_enc: 16'h0,    exp_pc: 16'h0};
        tbl[5] = '{s: mk(0, 1, 0, 0, 0, 16'h0), exp_req: 0, exp_addr: 16'h0001, exp_vld: 1, exp_enc: 16'h1234, exp_pc: 16'h0000};
        tbl[6] = '{s: mk(0, 0, 0, 0, 0, 16'h0), exp_req: 1, exp_addr: 16'h0001, exp_vld: 1, exp_enc: 16'h1234, exp_pc: 16'h0000};
        tbl[7] = '{s: mk(0, 0, 3, 0, 0, 16'h0), exp_req: 1, exp_addr: 16'h0001, exp_vld: 0, exp_enc: 16'h0,    exp_pc: 16'h0};

        @(negedge clk);
        do_reset();

        // Basic fetch: nibbles 4,3,2,1 form 0x1234, valid six cycles after release
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s);
            check($sformatf("tbl%0d_req", i),  32'(mem_req),  32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
            check($sformatf("tbl%0d_vld", i),  32'(enc_vld),  32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) begin
                check($sformatf("tbl%0d_enc", i), 32'(enc), 32'(tbl[i].exp_enc));
                check($sformatf("tbl%0d_pc", i),  32'(pc),  32'(tbl[i].exp_pc));
            end
        end

        // Back-pressure: stalled consumer, memory always ready
        bctr = 0;
        for (int i = 0; i < 40; i++) begin
            s = mk(mem_req && pend.size() == 0, pend.size() > 0, 2'(bctr), 1, 0, 16'h0);
            step(s);
            bctr++;
        end
        check("bp_vld",  32'(enc_vld),  32'h1);
        check("bp_pc",   32'(pc),       32'h0001);
        check("bp_enc",  32'(enc),      32'(mem_word(16'h0001)));
        check("bp_req",  32'(mem_req),  32'h0);
        check("bp_addr", 32'(mem_addr), 32'h0003);
        // Release: exactly one pop per ctr==3, memory held off
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 2'(i), 0, 0, 16'h0));
            check("bp_hold1", 32'(pc), 32'h0001);
        end
        step(mk(0, 0, 3, 0, 0, 16'h0));
        check("bp_pop1_pc",  32'(pc),      32'h0002);
        check("bp_pop1_vld", 32'(enc_vld), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(mk(0, 0, 2'(i), 0, 0, 16'h0));
            check("bp_hold2", 32'(pc), 32'h0002);
        end
        step(mk(0, 0, 3, 0, 0, 16'h0));
        check("bp_pop2_vld", 32'(enc_vld), 32'h0);
        check("bp_req_on",   32'(mem_req), 32'h1);

        // Redirect mid-RECV, with one word already buffered
        do_reset();
        step(mk(0, 0, 0, 0, 0, 16'h0));
        step(mk(1, 0, 0, 0, 0, 16'h0));
        repeat (4) step(mk(0, 1, 0, 0, 0, 16'h0));
        step(mk(0, 0, 0, 0, 0, 16'h0));
        step(mk(1, 0, 0, 0, 0, 16'h0));
        repeat (2) step(mk(0, 1, 0, 0, 0, 16'h0));
        check("rr_pre_vld", 32'(enc_vld), 32'h1);
        step(mk(0, 0, 0, 0, 1, 16'h0100));
        check("rr_vld",  32'(enc_vld),  32'h0);
        check("rr_addr", 32'(mem_addr), 32'h0100);
        check("rr_req",  32'(mem_req),  32'h0);
        repeat (2) begin
            step(mk(0, 1, 0, 0, 0, 16'h0));
            check("rr_drain_vld", 32'(enc_vld), 32'h0);
            check("rr_drain_req", 32'(mem_req), 32'h0);
        end
        step(mk(0, 0, 0, 0, 0, 16'h0));
        check("rr_next_req",  32'(mem_req),  32'h1);
        check("rr_next_addr", 32'(mem_addr), 32'h0100);

        // Redirect together with ack: a whole word is drained
        step(mk(1, 0, 0, 0, 1, 16'h0200));
        check("ra_req",  32'(mem_req),  32'h0);
        check("ra_addr", 32'(mem_addr), 32'h0200);
        repeat (4) begin
            step(mk(0, 1, 0, 0, 0, 16'h0));
            check("ra_drain_req", 32'(mem_req), 32'h0);
            check("ra_drain_vld", 32'(enc_vld), 32'h0);
        end
        step(mk(0, 0, 0, 0, 0, 16'h0));
        check("ra_next_req",  32'(mem_req),  32'h1);
        check("ra_next_addr", 32'(mem_addr), 32'h0200);

        // PC wrap: redirect in REQ without ack, then fetch 0xFFFF and 0x0000
        step(mk(0, 0, 0, 0, 1, 16'hFFFF));
        check("pw_req",  32'(mem_req),  32'h1);
        check("pw_addr", 32'(mem_addr), 32'hFFFF);
        step(mk(1, 0, 0, 0, 0, 16'h0));
        check("pw_wrap_addr", 32'(mem_addr), 32'h0000);
        repeat (4) step(mk(0, 1, 0, 0, 0, 16'h0));
        step(mk(0, 0, 0, 0, 0, 16'h0));
        step(mk(1, 0, 0, 0, 0, 16'h0));
        repeat (4) step(mk(0, 1, 0, 0, 0, 16'h0));
        check("pw_pc0",  32'(pc),  32'hFFFF);
        check("pw_enc0", 32'(enc), 32'(mem_word(16'hFFFF)));
        step(mk(0, 0, 3, 0, 0, 16'h0));
        check("pw_pc1",  32'(pc),      32'h0000);
        check("pw_vld1", 32'(enc_vld), 32'h1);

        // Asynchronous reset during the third nibble
        do_reset();
        step(mk(0, 0, 0, 0, 0, 16'h0));
        step(mk(1, 0, 0, 0, 0, 16'h0));
        repeat (2) step(mk(0, 1, 0, 0, 0, 16'h0));
        reset_mid_cycle(mk(0, 1, 0, 0, 0, 16'h0));
        step(mk(0, 1, 0, 0, 0, 16'h0));   // stale fourth nibble, ignored
        check("ar_req",  32'(mem_req),  32'h1);
        check("ar_addr", 32'(mem_addr), 32'h0000);
        check("ar_vld",  32'(enc_vld),  32'h0);
        step(mk(1, 0, 0, 0, 0, 16'h0));
        repeat (4) step(mk(0, 1, 0, 0, 0, 16'h0));
        check("ar_enc", 32'(enc), 32'h1234);
        check("ar_pc",  32'(pc),  32'h0000);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            s.ack   = mem_req && pend.size() == 0 && ($urandom_range(2, 0) != 0);
            s.dv    = pend.size() > 0 && ($urandom_range(3, 0) != 0);
            s.ctr   = 2'($urandom);
            s.stall = ($urandom_range(3, 0) == 0);
            s.redir = ($urandom_range(39, 0) == 0);
            s.rpc   = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(499, 0) == 0) reset_mid_cycle(s);
            else                             step(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
